// File: rtl/hilo_sched_if.sv
// Execute-stage to HI/LO unit handshake: request/operands in, status and
// architectural HI/LO out.
interface hilo_sched_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output req_valid, req_op, src_a, src_b, flush,
                    input  busy, done, hi, lo);
    modport slave  (input  req_valid, req_op, src_a, src_b, flush,
                    output busy, done, hi, lo);
endinterface

// File: rtl/hilo_sched.sv
// HI/LO multiply/divide scheduler: fixed-latency multiply-accumulate and a
// 32-step restoring divider with a final sign-fix cycle.
module hilo_sched #(
    parameter int MUL_LAT = 2
) (
    input logic          clk,
    input logic          rst,
    hilo_sched_if.slave  bus
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state;
    logic [2:0]  op;
    logic [31:0] op_a, op_b, quo, rem;
    logic [4:0]  cnt;
    logic        neg_q, neg_r;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        accept;
    logic        div_signed;
    logic [31:0] a_mag, b_mag;
    logic [32:0] shifted, trial;
    logic [63:0] ext_a, ext_b, prod, acc;

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.hi   = hi;
    assign bus.lo   = lo;

    assign accept     = (state == IDLE) && bus.req_valid && !bus.flush;
    assign div_signed = (bus.req_op == OP_DIV);
    assign a_mag      = (div_signed && bus.src_a[31]) ? -bus.src_a : bus.src_a;
    assign b_mag      = (div_signed && bus.src_b[31]) ? -bus.src_b : bus.src_b;

    // quo starts as the dividend and shifts out MSB-first as quotient bits enter
    assign shifted = {rem, quo[31]};
    assign trial   = shifted - {1'b0, op_b};

    always_comb begin
        ext_a = (op == OP_MULTU) ? {32'b0, op_a} : {{32{op_a[31]}}, op_a};
        ext_b = (op == OP_MULTU) ? {32'b0, op_b} : {{32{op_b[31]}}, op_b};
        prod  = ext_a * ext_b;
        case (op)
            OP_MADD: acc = {hi, lo} + prod;
            OP_MSUB: acc = {hi, lo} - prod;
            default: acc = prod;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op    <= OP_MULT;
            op_a  <= '0;
            op_b  <= '0;
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    case (bus.req_op)
                        OP_MTHI: begin hi <= bus.src_a; done <= 1'b1; end
                        OP_MTLO: begin lo <= bus.src_a; done <= 1'b1; end
                        OP_DIV, OP_DIVU: begin
                            if (bus.src_b == '0) begin
                                done <= 1'b1;
                            end else begin
                                quo   <= a_mag;
                                op_b  <= b_mag;
                                rem   <= '0;
                                cnt   <= '0;
                                neg_q <= div_signed && (bus.src_a[31] ^ bus.src_b[31]);
                                neg_r <= div_signed && bus.src_a[31];
                                state <= DIV;
                                busy  <= 1'b1;
                            end
                        end
                        default: begin
                            op    <= bus.req_op;
                            op_a  <= bus.src_a;
                            op_b  <= bus.src_b;
                            cnt   <= '0;
                            state <= MUL;
                            busy  <= 1'b1;
                        end
                    endcase
                end
                // completion wins over a simultaneous flush
                MUL: begin
                    if (cnt == 5'(MUL_LAT - 1)) begin
                        {hi, lo} <= acc;
                        done     <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else if (bus.flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DIV: begin
                    if (bus.flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem <= trial[32] ? shifted[31:0] : trial[31:0];
                        quo <= {quo[30:0], ~trial[32]};
                        if (cnt == 5'd31) state <= FIX;
                        else              cnt   <= cnt + 5'd1;
                    end
                end
                FIX: begin
                    lo    <= neg_q ? -quo : quo;
                    hi    <= neg_r ? -rem : rem;
                    done  <= 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
